// File: rtl/onehot_sweep_decoder.sv
// Registered one-hot LED decoder with direct, sweep-up, sweep-down and ping-pong modes.
// Optional ONEHOT_SWEEP_HOLD_EN adds a hold input that freezes a running sweep.
//
// mode | meaning
// 00   | direct: pos follows sw
// 01   | sweep up, wrap N-1 -> 0
// 10   | sweep down, wrap 0 -> N-1
// 11   | ping-pong, endpoints shown once
module onehot_sweep_decoder #(
    parameter int SEL_W    = 3,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        sw,
    input  logic [1:0]              mode,
`ifdef ONEHOT_SWEEP_HOLD_EN
    input  logic                    hold,
`endif
    output logic [(1<<SEL_W)-1:0]   led,
    output logic [SEL_W-1:0]        pos
);

    localparam int N  = 1 << SEL_W;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]    CNT_TC  = CW'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] POS_MAX = SEL_W'(N - 1);
    localparam logic [N-1:0]     LED_MSB = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_PING   = 2'b11
    } mode_t;

    mode_t            mode_q;
    logic [CW-1:0]    cnt;
    logic             dir;

    logic [SEL_W-1:0] pos_n;
    logic [CW-1:0]    cnt_n;
    logic             dir_n;
    logic             dir_cur;
    logic             tick;
    logic             hold_eff;

`ifdef ONEHOT_SWEEP_HOLD_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    assign tick = (cnt == CNT_TC);

    always_comb begin
        pos_n   = pos;
        cnt_n   = cnt;
        dir_n   = dir;
        dir_cur = dir;
        if (mode == MODE_DIRECT) begin
            pos_n = sw;
            cnt_n = '0;
        end else if (mode_q == MODE_DIRECT) begin
            // sweep entry wins over any tick in the same cycle
            pos_n = sw;
            cnt_n = '0;
            dir_n = 1'b0;
        end else if (!hold_eff) begin
            if (mode == MODE_PING && mode_q != MODE_PING)
                dir_cur = 1'b0;
            dir_n = dir_cur;
            cnt_n = tick ? '0 : cnt + 1'b1;
            if (tick) begin
                case (mode)
                    MODE_UP:   pos_n = pos + 1'b1;
                    MODE_DOWN: pos_n = pos - 1'b1;
                    default: begin
                        if (!dir_cur && pos == POS_MAX) begin
                            dir_n = 1'b1;
                            pos_n = pos - 1'b1;
                        end else if (dir_cur && pos == '0) begin
                            dir_n = 1'b0;
                            pos_n = pos + 1'b1;
                        end else begin
                            pos_n = dir_cur ? pos - 1'b1 : pos + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos    <= '0;
            led    <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
            mode_q <= MODE_DIRECT;
        end else begin
            pos    <= pos_n;
            led    <= LED_MSB >> pos_n;
            cnt    <= cnt_n;
            dir    <= dir_n;
            mode_q <= mode_t'(mode);
        end
    end

endmodule

// File: tb/tb_onehot_sweep_decoder.sv
// Directed bench for onehot_sweep_decoder at SEL_W=3, TICK_DIV=4.
// The hold scenario is built only when ONEHOT_SWEEP_HOLD_EN is defined.
module tb_onehot_sweep_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sw;
    logic [1:0] mode;
    logic       hold;
    logic [7:0] led;
    logic [2:0] pos;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onehot_sweep_decoder #(.SEL_W(3), .TICK_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .mode (mode),
`ifdef ONEHOT_SWEEP_HOLD_EN
        .hold (hold),
`endif
        .led  (led),
        .pos  (pos)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'b00; sw = 3'd0; hold = 1'b0;
        step(2);
        total++;
        if (led !== 8'h00) begin bad++; $display("FAIL reset_led: got %h want 00", led); end
        total++;
        if (pos !== 3'd0) begin bad++; $display("FAIL reset_pos: got %0d want 0", pos); end
        rst = 1'b0;
        step(1);
        total++;
        if (led !== 8'h80) begin bad++; $display("FAIL post_reset_led: got %h want 80", led); end
        total++;
        if (pos !== 3'd0) begin bad++; $display("FAIL post_reset_pos: got %0d want 0", pos); end
    endtask

    task automatic test_direct();
        logic [7:0] exp_led [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        mode = 2'b00;
        for (int i = 0; i < 8; i++) begin
            sw = 3'(i);
            step(1);
            total++;
            if (led !== exp_led[i]) begin bad++; $display("FAIL direct_led[%0d]: got %h want %h", i, led, exp_led[i]); end
            total++;
            if (pos !== 3'(i)) begin bad++; $display("FAIL direct_pos[%0d]: got %0d want %0d", i, pos, i); end
        end
    endtask

    task automatic test_sweep_up();
        logic [2:0] exp_pos [3] = '{3'd7, 3'd0, 3'd1};
        mode = 2'b00; sw = 3'd6;
        step(1);
        mode = 2'b01;
        step(1);
        total++;
        if (pos !== 3'd6) begin bad++; $display("FAIL up_entry_pos: got %0d want 6", pos); end
        total++;
        if (led !== 8'h02) begin bad++; $display("FAIL up_entry_led: got %h want 02", led); end
        step(3);
        total++;
        if (pos !== 3'd6) begin bad++; $display("FAIL up_early_step: got %0d want 6", pos); end
        step(1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(4);
            total++;
            if (pos !== exp_pos[i]) begin bad++; $display("FAIL up_step[%0d]: got %0d want %0d", i, pos, exp_pos[i]); end
        end
        mode = 2'b00;
        step(1);
    endtask

    task automatic test_pingpong();
        logic [2:0] exp_pos [11] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
        logic [7:0] msb = 8'h80;
        mode = 2'b00; sw = 3'd5;
        step(1);
        mode = 2'b11;
        step(1);
        total++;
        if (pos !== 3'd5) begin bad++; $display("FAIL ping_entry_pos: got %0d want 5", pos); end
        for (int i = 0; i < 11; i++) begin
            step(4);
            total++;
            if (pos !== exp_pos[i]) begin bad++; $display("FAIL ping_pos[%0d]: got %0d want %0d", i, pos, exp_pos[i]); end
            total++;
            if (led !== (msb >> exp_pos[i])) begin bad++; $display("FAIL ping_led[%0d]: got %h want %h", i, led, msb >> exp_pos[i]); end
        end
        mode = 2'b00;
        step(1);
    endtask

    task automatic test_down_reset();
        mode = 2'b00; sw = 3'd1;
        step(1);
        mode = 2'b10;
        step(1);
        total++;
        if (pos !== 3'd1) begin bad++; $display("FAIL down_entry_pos: got %0d want 1", pos); end
        step(4);
        total++;
        if (pos !== 3'd0) begin bad++; $display("FAIL down_step0: got %0d want 0", pos); end
        step(4);
        total++;
        if (pos !== 3'd7) begin bad++; $display("FAIL down_wrap: got %0d want 7", pos); end
        total++;
        if (led !== 8'h01) begin bad++; $display("FAIL down_wrap_led: got %h want 01", led); end
        rst = 1'b1;
        step(1);
        total++;
        if (led !== 8'h00) begin bad++; $display("FAIL midreset_led: got %h want 00", led); end
        total++;
        if (pos !== 3'd0) begin bad++; $display("FAIL midreset_pos: got %0d want 0", pos); end
        rst = 1'b0;
        step(1);
        total++;
        if (pos !== 3'd1) begin bad++; $display("FAIL reentry_pos: got %0d want 1", pos); end
        total++;
        if (led !== 8'h40) begin bad++; $display("FAIL reentry_led: got %h want 40", led); end
        step(3);
        total++;
        if (pos !== 3'd1) begin bad++; $display("FAIL reentry_early: got %0d want 1", pos); end
        step(1);
        total++;
        if (pos !== 3'd0) begin bad++; $display("FAIL reentry_step: got %0d want 0", pos); end
        mode = 2'b00;
        step(1);
    endtask

`ifdef ONEHOT_SWEEP_HOLD_EN
    task automatic test_hold();
        mode = 2'b00; sw = 3'd2; hold = 1'b0;
        step(1);
        mode = 2'b01;
        step(1);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            total++;
            if (pos !== 3'd2) begin bad++; $display("FAIL hold_pos[%0d]: got %0d want 2", i, pos); end
        end
        hold = 1'b0;
        step(3);
        total++;
        if (pos !== 3'd2) begin bad++; $display("FAIL hold_release_early: got %0d want 2", pos); end
        step(1);
        total++;
        if (pos !== 3'd3) begin bad++; $display("FAIL hold_release_step: got %0d want 3", pos); end
        mode = 2'b00;
        step(1);
    endtask
`endif

    initial begin
        rst = 1'b1; sw = 3'd0; mode = 2'b00; hold = 1'b0;
        test_reset();
        test_direct();
        test_sweep_up();
        test_pingpong();
        test_down_reset();
`ifdef ONEHOT_SWEEP_HOLD_EN
        test_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
